// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - op code constants presented on the `op` port
//   - FSM state encoding
//   - div_zero flag values
//   - small op-decode helpers
package muldiv_pkg;

  // Op codes
  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
  localparam logic [2:0] OpMfhi  = 3'b110;
  localparam logic [2:0] OpMflo  = 3'b111;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMul  = 3'd1,
    StDiv  = 3'd2,
    StFix  = 3'd3,
    StZero = 3'd4
  } state_e;

  // div_zero flag values
  localparam logic DivZeroSet = 1'b1;
  localparam logic DivZeroClr = 1'b0;

  // mult/multu/div/divu all have op[2] clear
  function automatic logic is_muldiv(input logic [2:0] code);
    return ~code[2];
  endfunction

  function automatic logic is_div(input logic [2:0] code);
    return ~code[2] & code[1];
  endfunction

  // mult and div are the signed variants
  function automatic logic is_signed_op(input logic [2:0] code);
    return ~code[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// div_iter: one restoring-division step.
//   rem      current partial remainder (always < divisor)
//   quo      dividend bits still to shift in (MSB first); quotient bits enter at the LSB
//   divisor  unsigned divisor
//   rem_next / quo_next  state after retiring one quotient bit
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    // Because rem < divisor, shifted < 2*divisor, so diff[WIDTH] is exactly the borrow.
    if (diff[WIDTH]) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine with architectural HI/LO registers.
//   clock, resetn        clock and asynchronous active-low reset
//   op_valid, op         op presented by the execute stage (see muldiv_pkg op codes)
//   src_a, src_b         forwarded rs / rt operands
//   flush                abort in-flight op; the op presented this cycle is not accepted
//   ex_stall             combinational execute-stage hold
//   done                 one-cycle pulse when a mul/div result lands in HI/LO
//   div_zero             sticky: last accepted div/divu had a zero divisor
//   hi, lo               architectural HI/LO
//   hilo_rdata           hi for mfhi, lo for mflo, else 0
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             ex_stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hilo_rdata
);

  localparam int unsigned CntW     = $clog2(WIDTH) + 1;
  localparam int unsigned MulSteps = WIDTH / MUL_BITS;
  localparam logic [CntW-1:0] MulLoad = CntW'(MulSteps - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Shared datapath: {work_hi, work_lo} is the product register for mul, and
  // remainder/dividend-quotient for div. operand holds multiplicand or divisor.
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             is_mul_q, is_mul_d;
  logic             neg_lo_q, neg_lo_d;   // negate product / quotient in FIX
  logic             neg_hi_q, neg_hi_d;   // negate remainder in FIX
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH+MUL_BITS-1:0] mul_pp;
  logic [WIDTH+MUL_BITS-1:0] mul_sum;
  logic [WIDTH-1:0]          div_rem_next, div_quo_next;

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // The done cycle still presents the mul/div that just completed; it must not
  // be accepted a second time, so mul/div acceptance waits one more cycle.
  assign accept = op_valid & ~flush & (state_q == StIdle) & ~(done_q & is_muldiv(op));

  assign a_neg = is_signed_op(op) & src_a[WIDTH-1];
  assign b_neg = is_signed_op(op) & src_b[WIDTH-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  // Shift-add multiplier: retire MUL_BITS multiplier bits from work_lo per cycle.
  always_comb begin
    mul_pp  = {{MUL_BITS{1'b0}}, operand_q} * {{WIDTH{1'b0}}, work_lo_q[MUL_BITS-1:0]};
    mul_sum = {{MUL_BITS{1'b0}}, work_hi_q} + mul_pp;
  end

  div_iter #(
    .WIDTH (WIDTH)
  ) u_div_iter (
    .rem      (work_hi_q),
    .quo      (work_lo_q),
    .divisor  (operand_q),
    .rem_next (div_rem_next),
    .quo_next (div_quo_next)
  );

  always_comb begin
    prod     = {work_hi_q, work_lo_q};
    prod_fix = neg_lo_q ? -prod : prod;
    quo_fix  = neg_lo_q ? -work_lo_q : work_lo_q;
    rem_fix  = neg_hi_q ? -work_hi_q : work_hi_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_hi_d  = work_hi_q;
    work_lo_d  = work_lo_q;
    operand_d  = operand_q;
    is_mul_d   = is_mul_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    if (flush && (state_q != StIdle)) begin
      // Abort: architectural state untouched, no done.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            unique case (op)
              OpMthi: hi_d = src_a;
              OpMtlo: lo_d = src_a;
              OpMfhi, OpMflo: ;
              OpMult, OpMultu: begin
                state_d   = StMul;
                cnt_d     = MulLoad;
                work_hi_d = '0;
                work_lo_d = a_mag;
                operand_d = b_mag;
                is_mul_d  = 1'b1;
                neg_lo_d  = a_neg ^ b_neg;
                neg_hi_d  = 1'b0;
              end
              default: begin  // OpDiv, OpDivu
                if (src_b == '0) begin
                  state_d   = StZero;
                  work_hi_d = src_a;
                end else begin
                  state_d    = StDiv;
                  cnt_d      = DivLoad;
                  work_hi_d  = '0;
                  work_lo_d  = a_mag;
                  operand_d  = b_mag;
                  is_mul_d   = 1'b0;
                  neg_lo_d   = a_neg ^ b_neg;
                  neg_hi_d   = a_neg;
                  div_zero_d = DivZeroClr;
                end
              end
            endcase
          end
        end
        StMul: begin
          {work_hi_d, work_lo_d} = {mul_sum, work_lo_q[WIDTH-1:MUL_BITS]};
          if (cnt_q == '0) state_d = StFix;
          else             cnt_d   = cnt_q - 1'b1;
        end
        StDiv: begin
          work_hi_d = div_rem_next;
          work_lo_d = div_quo_next;
          if (cnt_q == '0) state_d = StFix;
          else             cnt_d   = cnt_q - 1'b1;
        end
        StFix: begin
          if (is_mul_q) begin
            {hi_d, lo_d} = prod_fix;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
        StZero: begin
          hi_d       = work_hi_q;
          lo_d       = '1;
          div_zero_d = DivZeroSet;
          done_d     = 1'b1;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      work_hi_q  <= '0;
      work_lo_q  <= '0;
      operand_q  <= '0;
      is_mul_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= DivZeroClr;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_hi_q  <= work_hi_d;
      work_lo_q  <= work_lo_d;
      operand_q  <= operand_d;
      is_mul_q   <= is_mul_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  // The issuing mul/div waits for its own result; everything waits while busy.
  assign ex_stall = ~flush & op_valid &
                    ((state_q != StIdle) | (is_muldiv(op) & ~done_q));

  always_comb begin
    unique case (op)
      OpMfhi:  hilo_rdata = hi_q;
      OpMflo:  hilo_rdata = lo_q;
      default: hilo_rdata = '0;
    endcase
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;
  assign done     = done_q;

endmodule
